// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus between fetch unit and memory
interface instr_fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              Mem_Read;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_Data;

  modport master (
    output Mem_Read,
    output Mem_Addr,
    input  Mem_Ack,
    input  Mem_Data
  );

  modport slave (
    input  Mem_Read,
    input  Mem_Addr,
    output Mem_Ack,
    output Mem_Data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-fetch FSM with conditional branch redirect and memory timeout
module instr_fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Branch_Valid,
  input  logic [ADDR_W-1:0] Branch_Target,
  input  logic              Branch_Flag,
  input  logic              Branch_Sense,
  instr_fetch_unit_if.master mem,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              Instr_Valid,
  output logic              Branch_Taken,
  output logic              Fetch_Error,
  output logic              Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_UPDATE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              branch_taken_q, branch_taken_d;
  logic              branch_cond;
  logic              mem_read;
  logic              instr_valid;
  logic              fetch_error;

  assign branch_cond = ~(Branch_Sense ^ Branch_Flag);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    cnt_d          = cnt_q;
    branch_taken_d = 1'b0;
    mem_read       = 1'b0;
    instr_valid    = 1'b0;
    fetch_error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A branch request swallows a simultaneous Start; it is not replayed later.
        if (Branch_Valid) begin
          if (branch_cond) begin
            pc_d           = Branch_Target;
            branch_taken_d = 1'b1;
          end
        end else if (Start) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        mem_read = 1'b1;
        // Ack in the last allowed cycle still completes the fetch.
        if (mem.Mem_Ack) begin
          ir_d    = mem.Mem_Data;
          state_d = S_UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_UPDATE: begin
        instr_valid = 1'b1;
        pc_d        = pc_q + PC_INC;
        state_d     = S_IDLE;
      end
      S_ERROR: begin
        fetch_error = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      pc_q           <= PC_RESET;
      ir_q           <= '0;
      cnt_q          <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      cnt_q          <= cnt_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign mem.Mem_Read = mem_read;
  assign mem.Mem_Addr = pc_q;
  assign IR           = ir_q;
  assign PC           = pc_q;
  assign Instr_Valid  = instr_valid;
  assign Branch_Taken = branch_taken_q;
  assign Fetch_Error  = fetch_error;
  assign Busy         = (state_q != S_IDLE);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 16: instruction and memory data width.
REQ-002 Parameter ADDR_W, default 16: PC and memory address width.
REQ-003 Parameter PC_STEP, default 2: PC increment per completed fetch.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 Parameter TIMEOUT, default 8, legal range 2..255: maximum REQ cycles allowed without Mem_Ack.
REQ-006 The block SHALL use one clock, Clk, and a synchronous, active-high reset, Reset.
REQ-007 Ports (name, direction, width, meaning):
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request one fetch; sampled in IDLE only.
- Branch_Valid  in  1  redirect request; sampled in IDLE only.
- Branch_Target  in  ADDR_W  redirect address.
- Branch_Flag  in  1  selected condition flag (M/Z/O/C), chosen outside the block.
- Branch_Sense  in  1  required flag polarity (IR bit 7).
- Mem_Ack  in  1  memory read data valid.
- Mem_Data  in  DATA_W  memory read data.
- Mem_Read  out  1  read request.
- Mem_Addr  out  ADDR_W  read address.
- IR  out  DATA_W  last fetched instruction.
- PC  out  ADDR_W  program counter.
- Instr_Valid  out  1  one-cycle pulse: IR is newly updated.
- Branch_Taken  out  1  one-cycle pulse: PC was redirected.
- Fetch_Error  out  1  one-cycle pulse: memory timeout.
- Busy  out  1  high whenever the state is not IDLE.

Function
REQ-008 The FSM SHALL have four states, IDLE, REQ, UPDATE and ERROR, all registered.
REQ-009 IDLE: if Branch_Valid=1 and (Branch_Sense XNOR Branch_Flag)=1, then PC<=Branch_Target and Branch_Taken=1 in the next cycle; the state stays IDLE.
REQ-010 IDLE: if Branch_Valid=1 but the condition is false, PC SHALL NOT change and no pulse SHALL be generated.
REQ-011 IDLE with Start=1 and Branch_Valid=0: the FSM SHALL move to REQ and clear the timeout counter.
REQ-012 IDLE with Start=1 and Branch_Valid=1 in the same cycle: the branch SHALL take priority, Start SHALL be dropped (not queued), and the state stays IDLE.
REQ-013 REQ: Mem_Read=1 and Mem_Addr=PC, both combinational from state and PC; Mem_Addr SHALL equal PC in every state.
REQ-014 REQ with Mem_Ack=1: IR<=Mem_Data on that clock edge, and the next state SHALL be UPDATE.
REQ-015 REQ with Mem_Ack=0: the counter SHALL increment; when counter==TIMEOUT-1 and Mem_Ack=0, the next state SHALL be ERROR.
REQ-016 If Mem_Ack=1 arrives in the final allowed REQ cycle, the ack SHALL win (UPDATE), not ERROR.
REQ-017 UPDATE: Instr_Valid=1 for exactly this cycle; PC<=(PC+PC_STEP) mod 2^ADDR_W on the exit edge; next state SHALL be IDLE.
REQ-018 ERROR: Fetch_Error=1 for one cycle and Mem_Read=0; PC and IR SHALL be unchanged; next state SHALL be IDLE.
REQ-019 Mem_Ack SHALL be ignored in IDLE, UPDATE and ERROR; Start and Branch_Valid SHALL be ignored outside IDLE.
REQ-020 Minimum latency: Start in cycle n, Mem_Ack in n+1 -> Instr_Valid in n+2, incremented PC visible in n+3, next Start accepted in n+3.
REQ-021 PC wrap-around: at PC=2^ADDR_W-PC_STEP, a fetch SHALL wrap PC to 0 with no flag.

Reset
REQ-022 When Reset=1 at a clock edge, the block SHALL take: state=IDLE, PC=RESET_PC, IR=0, counter=0, Instr_Valid=0, Branch_Taken=0, Fetch_Error=0, Busy=0, Mem_Read=0.
REQ-023 Reset SHALL take priority over every other input, including mid-REQ; no UPDATE and no ERROR SHALL follow a reset.

Verification
REQ-024 Basic fetch: Reset; Start; Mem_Ack=1 with Mem_Data=16'h0F01 in the first REQ cycle -> Mem_Addr=0, IR=16'h0F01, Instr_Valid pulse in cycle n+2, PC=2.
REQ-025 Wait states: Mem_Ack delayed by 5 cycles (TIMEOUT=8) -> Mem_Read held high for 6 cycles, IR latched, PC+2; a second variant with Mem_Ack withheld -> Fetch_Error pulse after 8 REQ cycles, PC and IR unchanged.
REQ-026 Boundary ack: Mem_Ack=1 exactly in REQ cycle 8 (TIMEOUT=8) -> UPDATE, and no Fetch_Error.
REQ-027 Branch: Branch_Flag=1, Branch_Sense=1, Branch_Target=16'h1FFE -> PC=16'h1FFE with a Branch_Taken pulse; Branch_Sense=0 -> PC unchanged; Start and Branch_Valid together -> branch only, no Mem_Read.
REQ-028 Wrap and parameters: ADDR_W=16, PC=16'hFFFE, one fetch -> PC=0; repeat with DATA_W=32, ADDR_W=12, PC_STEP=4 at PC=12'hFFC -> PC=0.
REQ-029 Reset mid-REQ: Reset asserted on the 3rd REQ cycle -> next cycle IDLE, Mem_Read=0, PC=RESET_PC, and no pulses.
